// File: rtl/direction_input_if.sv
// Button/direction bundle between the board buttons, game logic and direction_input.
interface direction_input_if;
  logic       btn_left;
  logic       btn_up;
  logic       btn_right;
  logic       btn_down;
  logic       move_tick;
  logic [1:0] direction;
  logic       press_pulse;

  modport master (
    output btn_left, btn_up, btn_right, btn_down, move_tick,
    input  direction, press_pulse
  );

  modport slave (
    input  btn_left, btn_up, btn_right, btn_down, move_tick,
    output direction, press_pulse
  );
endinterface

// File: rtl/direction_input.sv
// Raw push-buttons -> debounced one-shot turn requests -> registered snake direction.
// Define DIRECTION_REVERSE_GUARD_EN to reject 180-degree reversals against the last move.
module direction_input #(
  parameter int DEBOUNCE_CYCLES = 125000,
  parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  direction_input_if.slave bus
);
  localparam int              CW        = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]   CNT_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [1:0]      DIR_RIGHT = 2'b10;

  // Bit index equals the direction code: LEFT, TOP, RIGHT, DOWN.
  logic [3:0] raw, pressed, rise;
  assign raw     = {bus.btn_down, bus.btn_right, bus.btn_up, bus.btn_left};
  assign pressed = BTN_ACTIVE_LOW ? ~raw : raw;

  for (genvar i = 0; i < 4; i++) begin : g_btn
    logic [1:0]    sync;
    logic [CW-1:0] cnt;
    logic          stable, stable_d;

    always_ff @(posedge clk) begin
      if (reset) begin
        sync     <= '0;
        cnt      <= '0;
        stable   <= 1'b0;
        stable_d <= 1'b0;
      end else begin
        sync     <= {sync[0], pressed[i]};
        stable_d <= stable;
        if (sync[1] == stable) begin
          cnt <= '0;
        end else if (cnt == CNT_LAST) begin
          stable <= sync[1];
          cnt    <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end

    assign rise[i] = stable & ~stable_d;
  end

  // Lowest code wins; losing simultaneous presses are dropped.
  logic       req_vld;
  logic [1:0] req;
  always_comb begin
    req_vld = |rise;
    req     = 2'b00;
    for (int i = 3; i >= 0; i--)
      if (rise[i]) req = 2'(i);
  end

  logic accept;
`ifdef DIRECTION_REVERSE_GUARD_EN
  logic [1:0] committed, ref_dir;
  // A tick this cycle commits the current direction, so guard against that one.
  assign ref_dir = bus.move_tick ? bus.direction : committed;
  assign accept  = req_vld && (req != (ref_dir ^ 2'b10));

  always_ff @(posedge clk) begin
    if (reset)              committed <= DIR_RIGHT;
    else if (bus.move_tick) committed <= bus.direction;
  end
`else
  logic unused_tick;
  assign unused_tick = bus.move_tick;
  assign accept      = req_vld;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.direction   <= DIR_RIGHT;
      bus.press_pulse <= 1'b0;
    end else begin
      bus.press_pulse <= accept;
      if (accept) bus.direction <= req;
    end
  end
endmodule

// File: tb/tb_direction_input.sv
// Directed + random bench for direction_input against a sample-window reference model.
module tb_direction_input;
  localparam int DC = 4;
`ifdef DIRECTION_REVERSE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] btn = 4'b0;
  logic       tick = 1'b0;
  int         checks = 0;
  int         errors = 0;

  direction_input_if bus();
  assign bus.btn_left  = btn[0];
  assign bus.btn_up    = btn[1];
  assign bus.btn_right = btn[2];
  assign bus.btn_down  = btn[3];
  assign bus.move_tick = tick;

  direction_input #(.DEBOUNCE_CYCLES(DC), .BTN_ACTIVE_LOW(1'b0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Model: a button's accepted level becomes L once the last DC post-sync
  // samples all read L; a 0->1 acceptance is a turn request on the next edge.
  bit         hist [4][$];
  bit         m_stable [4];
  bit         m_rise [4];
  logic [1:0] m_dir = 2'b10;
  logic [1:0] m_comm = 2'b10;
  logic       m_pulse = 1'b0;

  task automatic model_edge();
    bit         nr [4];
    bit         same;
    int         req;
    logic [1:0] refd;
    if (reset) begin
      for (int b = 0; b < 4; b++) begin
        hist[b] = {};
        repeat (DC + 1) hist[b].push_back(1'b0);
        m_stable[b] = 1'b0;
        m_rise[b]   = 1'b0;
      end
      m_dir = 2'b10; m_comm = 2'b10; m_pulse = 1'b0;
    end else begin
      for (int b = 0; b < 4; b++) begin
        same = 1'b1;
        for (int i = 1; i < DC; i++) if (hist[b][i] != hist[b][0]) same = 1'b0;
        nr[b] = 1'b0;
        if (same && hist[b][0] != m_stable[b]) begin
          m_stable[b] = hist[b][0];
          nr[b]       = hist[b][0];
        end
        hist[b].push_back(btn[b]);
        void'(hist[b].pop_front());
      end
      req = -1;
      for (int b = 3; b >= 0; b--) if (m_rise[b]) req = b;
      refd    = tick ? m_dir : m_comm;
      m_pulse = (req >= 0) && (!GUARD || 2'(req) != (refd ^ 2'b10));
      if (tick)    m_comm = m_dir;
      if (m_pulse) m_dir  = 2'(req);
      m_rise = nr;
    end
  endtask

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("direction", int'(bus.direction), int'(m_dir));
    chk("press_pulse", int'(bus.press_pulse), int'(m_pulse));
  endtask

  task automatic do_reset();
    reset = 1'b1; btn = 4'b0; tick = 1'b0;
    step(); step();
    reset = 1'b0;
  endtask

  task automatic press(input int b);
    btn[b] = 1'b1;
    repeat (8) step();
    btn[b] = 1'b0;
    repeat (8) step();
  endtask

  task automatic run_until_pulse(output int n);
    n = -1;
    for (int i = 1; i <= 30; i++) begin
      step();
      if (bus.press_pulse === 1'b1) begin n = i; break; end
    end
  endtask

  initial begin
    int n;
    for (int b = 0; b < 4; b++) repeat (DC + 1) hist[b].push_back(1'b0);

    // 1: idle after reset
    do_reset();
    chk("reset_dir", int'(bus.direction), 2);
    chk("reset_pulse", int'(bus.press_pulse), 0);
    repeat (100) step();
    chk("idle_dir", int'(bus.direction), 2);

    // 2: held TOP, latency DC+3 and a single pulse
    do_reset();
    repeat (9) step();
    btn[1] = 1'b1;
    run_until_pulse(n);
    chk("up_latency", n, DC + 3);
    chk("up_dir", int'(bus.direction), 1);
    repeat (20) step();
    btn[1] = 1'b0;
    repeat (10) step();

    // 3: bounce shorter than the debounce window
    do_reset();
    btn[1] = 1'b1; repeat (3) step();
    btn[1] = 1'b0; step();
    btn[1] = 1'b1; repeat (3) step();
    btn[1] = 1'b0; repeat (12) step();
    chk("bounce_dir", int'(bus.direction), 2);

    // 4: reversal guard
    do_reset();
    press(0);
    chk("rev_left", int'(bus.direction), GUARD ? 2 : 0);
    press(1);
    chk("turn_top", int'(bus.direction), 1);
    press(0);
    chk("fast_left", int'(bus.direction), GUARD ? 1 : 0);
    tick = 1'b1; step(); tick = 1'b0;
    press(0);
    chk("left_after_tick", int'(bus.direction), 0);

    // 5: simultaneous LEFT and DOWN from TOP
    do_reset();
    press(1);
    tick = 1'b1; step(); tick = 1'b0;
    btn[0] = 1'b1; btn[3] = 1'b1;
    repeat (8) step();
    btn = 4'b0;
    repeat (8) step();
    chk("prio_dir", int'(bus.direction), 0);

    // 6: reset mid-debounce with button held
    do_reset();
    btn[3] = 1'b1;
    repeat (4) step();
    reset = 1'b1; step(); reset = 1'b0;
    chk("midreset_dir", int'(bus.direction), 2);
    run_until_pulse(n);
    chk("midreset_latency", n, DC + 3);
    chk("midreset_down", int'(bus.direction), 3);
    btn = 4'b0;
    repeat (10) step();

    // random buttons, ticks and occasional reset
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      for (int b = 0; b < 4; b++) if ($urandom_range(9) == 0) btn[b] = ~btn[b];
      tick  = ($urandom_range(7) == 0);
      reset = ($urandom_range(499) == 0);
      step();
    end
    reset = 1'b0; tick = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
